// File: rtl/gpo_led_driver.sv
// -----------------------------------------------------------------------------
// gpo_led_driver
//
// Drives the board LED pads from the general-purpose output bus. Each channel
// stretches short GPO pulses to a minimum visible on-time. An optional shared
// PWM dims all LEDs together.
//
// Optional feature macro: LED_DIM_PWM_EN
//   defined   : shared PWM dimming with brightness latched at each period start.
//   undefined : led_o is active_o registered once; brightness_i is unused.
//
// Parameters:
//   Width         number of GPO / LED channels
//   StretchCycles minimum cycles active_o stays high after the last high
//                 sample of a channel (0 = plain one-cycle register)
//   PwmBits       width of the PWM counter and of the brightness value
//
// Ports:
//   clk_sys_i     system clock
//   rst_sys_i     synchronous, active-high reset
//   gp_i          GPO level bus, sampled every cycle
//   brightness_i  shared LED duty value (PWM build only)
//   active_o      stretched per-channel state, before PWM
//   led_o         LED pad drive, one cycle behind active_o
// -----------------------------------------------------------------------------
module gpo_led_driver #(
  parameter int unsigned Width         = 8,
  parameter int unsigned StretchCycles = 2500000,
  parameter int unsigned PwmBits       = 4
) (
  input  logic               clk_sys_i,
  input  logic               rst_sys_i,
  input  logic [Width-1:0]   gp_i,
  input  logic [PwmBits-1:0] brightness_i,
  output logic [Width-1:0]   active_o,
  output logic [Width-1:0]   led_o
);

  // A zero-cycle stretch still needs a 1-bit counter to stay legal.
  localparam int unsigned   CntW    = (StretchCycles > 0) ? $clog2(StretchCycles + 1) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(StretchCycles);

  logic [Width-1:0][CntW-1:0] cnt_q, cnt_d;
  logic [Width-1:0]           active_q, active_d;
  logic [Width-1:0]           led_q, led_d;

  // ---------------------------------------------------------------------------
  // Per-channel stretch. A high sample loads the counter; active stays high
  // while the counter is non-zero, so a single-cycle pulse yields
  // StretchCycles+1 high cycles and a re-trigger simply reloads the counter.
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < Width; i++) begin
      // NOTE: every output of a combinational block gets a default first, so no
      // path can leave it unassigned and infer a latch.
      cnt_d[i]    = cnt_q[i];
      active_d[i] = 1'b0;
      if (gp_i[i]) begin
        cnt_d[i]    = CntLoad;
        active_d[i] = 1'b1;
      end else if (cnt_q[i] != '0) begin
        cnt_d[i]    = cnt_q[i] - 1'b1;
        active_d[i] = 1'b1;
      end
    end
  end

`ifdef LED_DIM_PWM_EN
  // ---------------------------------------------------------------------------
  // Shared PWM. Brightness is only taken at the last count of a period so a
  // change never cuts a period short. All-ones means continuously on.
  // ---------------------------------------------------------------------------
  logic [PwmBits-1:0] pwm_cnt_q;
  logic [PwmBits-1:0] bright_q;
  logic               pwm_on;

  always_comb begin
    pwm_on = (&bright_q) | (pwm_cnt_q < bright_q);
    led_d  = active_q & {Width{pwm_on}};
  end

  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      pwm_cnt_q <= '0;
      bright_q  <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + 1'b1;
      if (&pwm_cnt_q) begin
        bright_q <= brightness_i;
      end
    end
  end
`else
  // Brightness has no meaning without the PWM; fold it into a sink.
  logic unused_brightness;

  always_comb begin
    unused_brightness = ^brightness_i;
    led_d             = active_q;
  end
`endif

  // ---------------------------------------------------------------------------
  // State registers. The counters are plain flops, so they are cleared with
  // everything else; a reset mid-stretch leaves no residual on-time.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_sys_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst_sys_i) begin
      cnt_q    <= '0;
      active_q <= '0;
      led_q    <= '0;
    end else begin
      cnt_q    <= cnt_d;
      active_q <= active_d;
      led_q    <= led_d;
    end
  end

  assign active_o = active_q;
  assign led_o    = led_q;

endmodule

// File: tb/tb_gpo_led_driver.sv
// -----------------------------------------------------------------------------
// tb_gpo_led_driver
//
// Scoreboard bench. The stimulus process drives one cycle at a time and pushes
// the hand-computed outputs for that cycle; the monitor samples on the falling
// edge and compares. Two instances: StretchCycles=10 and StretchCycles=0.
// Cycle t of a test is the interval after the t-th rising edge following the
// reset edge; cycle 0 shows the reset state.
// -----------------------------------------------------------------------------
module tb_gpo_led_driver;

  logic       clk_sys;
  logic       rst_sys;
  logic [7:0] gp;
  logic [3:0] brightness;
  logic [7:0] s10_active, s10_led;
  logic [7:0] s0_active, s0_led;

  int n_cmp  = 0;
  int n_fail = 0;

`ifdef LED_DIM_PWM_EN
  localparam bit LedChk = 1'b0;  // led_o is PWM-gated; covered by the PWM tests
`else
  localparam bit LedChk = 1'b1;
`endif

  typedef struct {
    string      name;
    int         t;
    bit         sel;      // 0: StretchCycles=10 instance, 1: StretchCycles=0
    logic [7:0] act;
    logic [7:0] led;
    bit         led_chk;
  } exp_t;

  exp_t sb_q[$];

  gpo_led_driver #(.Width(8), .StretchCycles(10), .PwmBits(4)) u_s10 (
    .clk_sys_i    (clk_sys),
    .rst_sys_i    (rst_sys),
    .gp_i         (gp),
    .brightness_i (brightness),
    .active_o     (s10_active),
    .led_o        (s10_led)
  );

  gpo_led_driver #(.Width(8), .StretchCycles(0), .PwmBits(4)) u_s0 (
    .clk_sys_i    (clk_sys),
    .rst_sys_i    (rst_sys),
    .gp_i         (gp),
    .brightness_i (brightness),
    .active_o     (s0_active),
    .led_o        (s0_led)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  // Monitor: outputs are valid every cycle; compare on the falling edge.
  initial begin
    exp_t       e;
    logic [7:0] got_a, got_l;
    forever begin
      @(negedge clk_sys);
      if (sb_q.size() > 0) begin
        e     = sb_q.pop_front();
        got_a = e.sel ? s0_active : s10_active;
        got_l = e.sel ? s0_led    : s10_led;
        n_cmp++;
        if (got_a !== e.act) begin
          n_fail++;
          $display("FAIL %s t=%0d active_o got %h expected %h", e.name, e.t, got_a, e.act);
        end
        if (e.led_chk) begin
          n_cmp++;
          if (got_l !== e.led) begin
            n_fail++;
            $display("FAIL %s t=%0d led_o got %h expected %h", e.name, e.t, got_l, e.led);
          end
        end
      end
    end
  end

  task automatic push(input string name, input int t, input bit sel,
                      input logic [7:0] act, input logic [7:0] led, input bit led_chk);
    exp_t e;
    e.name    = name;
    e.t       = t;
    e.sel     = sel;
    e.act     = act;
    e.led     = led;
    e.led_chk = led_chk;
    sb_q.push_back(e);
  endtask

  // Reset is driven for one cycle; the caller's first edge (t=0) samples it.
  task automatic start_test();
    @(posedge clk_sys);
    #1;
    rst_sys = 1'b1;
    gp      = 8'h00;
  endtask

  task automatic next_cycle();
    @(posedge clk_sys);
    #1;
    rst_sys = 1'b0;
  endtask

  logic [7:0] vec [12] = '{8'hA5, 8'h3C, 8'h00, 8'hFF, 8'h81, 8'h7E,
                           8'h12, 8'h34, 8'hC3, 8'h5A, 8'h01, 8'h80};

  initial begin
    rst_sys    = 1'b1;
    gp         = 8'h00;
    brightness = 4'd15;
    repeat (2) @(posedge clk_sys);

    // 1. Single pulse on bit 0 at t=5: active 6..16, led 7..17.
    start_test();
    for (int t = 0; t <= 20; t++) begin
      next_cycle();
      gp = (t == 5) ? 8'h01 : 8'h00;
      push("single_pulse", t, 1'b0,
           (t >= 6 && t <= 16) ? 8'h01 : 8'h00,
           (t >= 7 && t <= 17) ? 8'h01 : 8'h00, LedChk);
    end

    // 2. Re-trigger on bit 3 at t=5 and t=12: active 6..23, led 7..24.
    start_test();
    for (int t = 0; t <= 27; t++) begin
      next_cycle();
      gp = (t == 5 || t == 12) ? 8'h08 : 8'h00;
      push("retrigger", t, 1'b0,
           (t >= 6 && t <= 23) ? 8'h08 : 8'h00,
           (t >= 7 && t <= 24) ? 8'h08 : 8'h00, LedChk);
    end

    // 3. Pulse on bit 1 at t=5, reset during t=9: all zero from t=10.
    start_test();
    for (int t = 0; t <= 20; t++) begin
      next_cycle();
      gp = (t == 5) ? 8'h02 : 8'h00;
      if (t == 9) rst_sys = 1'b1;
      push("reset_mid_stretch", t, 1'b0,
           (t >= 6 && t <= 9) ? 8'h02 : 8'h00,
           (t >= 7 && t <= 9) ? 8'h02 : 8'h00, LedChk);
    end

    // 6. StretchCycles=0: active is gp delayed 1, led is gp delayed 2.
    start_test();
    for (int t = 0; t <= 14; t++) begin
      next_cycle();
      gp = (t < 12) ? vec[t] : 8'h00;
      push("pass_through", t, 1'b1,
           (t >= 1 && t <= 12) ? vec[t-1] : 8'h00,
           (t >= 2 && t <= 13) ? vec[t-2] : 8'h00, LedChk);
    end

`ifdef LED_DIM_PWM_EN
    // 4. PWM duty with gp held high. PWM count in cycle t is t%16; the first
    //    latch is at the edge starting cycle 16; led lags one cycle.
    for (int k = 0; k < 3; k++) begin
      int b;
      b = (k == 0) ? 5 : (k == 1) ? 15 : 0;
      brightness = 4'(b);
      start_test();
      for (int t = 0; t <= 64; t++) begin
        int  tp;
        bit  on;
        next_cycle();
        gp = 8'hFF;
        tp = t - 1;
        on = (tp >= 16) && ((b == 15) || ((tp % 16) < b));
        push($sformatf("pwm_duty_%0d", b), t, 1'b0,
             (t >= 1) ? 8'hFF : 8'h00, on ? 8'hFF : 8'h00, 1'b1);
      end
    end

    // 5. Brightness 4 -> 12 while pwm_cnt=2 of the period starting t=32:
    //    that period keeps 4 on-cycles, the next one has 12.
    start_test();
    for (int t = 0; t <= 64; t++) begin
      bit on;
      next_cycle();
      gp         = 8'hFF;
      brightness = (t < 34) ? 4'd4 : 4'd12;
      on = (t >= 17 && t <= 20) || (t >= 33 && t <= 36) || (t >= 49 && t <= 60);
      push("bright_change", t, 1'b0,
           (t >= 1) ? 8'hFF : 8'h00, on ? 8'hFF : 8'h00, 1'b1);
    end
`endif

    repeat (3) @(posedge clk_sys);
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected entries left, required 0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
